// File: rtl/run_len_detector_pkg.sv
// Shared constants and helpers for the run-length detector.
// Output mode encodings and the threshold clamp used by the detector.
package run_det_pkg;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  // len of 0 acts as 1, and anything above max_len acts as max_len.
  function automatic int unsigned clamp_thr(input int unsigned len, input int unsigned max_len);
    int unsigned thr;
    if (len == 32'd0) begin
      thr = 32'd1;
    end else if (len > max_len) begin
      thr = max_len;
    end else begin
      thr = len;
    end
    return thr;
  endfunction

endpackage

// File: rtl/run_len_detector_sat_counter.sv
// Saturating up-counter with synchronous clear, load-to-one and increment.
// Priority is clr > load1 > inc. The next value is exported so that callers can see it before the edge.
module sat_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt_q,
  output logic [W-1:0] cnt_d
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // next-count selection
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = W'(1);
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/run_len_detector.sv
// Detects runs of identical serial bits reaching a run-time threshold.
// Provides a level or single-pulse output and a wrapping count of detected runs.
module run_len_detector
  import run_det_pkg::*;
#(
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = $clog2(MAX_LEN + 1),
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             w,
  input  logic [CNT_W-1:0] len,
  input  logic             mode,
  output logic             z,
  output logic             z_val,
  output logic [CNT_W-1:0] run_cnt,
  output logic [EVT_W-1:0] evt_cnt
);

  logic [CNT_W-1:0] thr_s;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             run_start_s;
  logic             z_val_q, z_val_d;
  logic             hit_q, hit_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

  assign thr_s       = CNT_W'(clamp_thr(32'(len), 32'(MAX_LEN)));
  // A zero count means nothing has been sampled since reset, so any bit starts a run.
  assign run_start_s = en && ((cnt_q == '0) || (w != z_val_q));

  sat_counter #(
    .W   (CNT_W),
    .MAX (MAX_LEN)
  ) u_run_cnt (
    .clk   (clk),
    .clr   (clr),
    .load1 (run_start_s),
    .inc   (en && !run_start_s),
    .cnt_q (cnt_q),
    .cnt_d (cnt_d)
  );

  // run value, hit strobe and event counter next state
  always_comb begin
    z_val_d   = z_val_q;
    hit_d     = 1'b0;
    evt_cnt_d = evt_cnt_q;
    if (clr) begin
      z_val_d   = 1'b0;
      hit_d     = 1'b0;
      evt_cnt_d = '0;
    end else begin
      if (run_start_s) begin
        z_val_d = w;
      end else begin
        z_val_d = z_val_q;
      end
      // Saturated counts do not move, so they cannot refire.
      hit_d = en && (cnt_d == thr_s) && ((cnt_d != cnt_q) || run_start_s);
      if (hit_d) begin
        evt_cnt_d = evt_cnt_q + EVT_W'(1);
      end else begin
        evt_cnt_d = evt_cnt_q;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    z_val_q   <= z_val_d;
    hit_q     <= hit_d;
    evt_cnt_q <= evt_cnt_d;
  end

  // output select: live len feeds the level compare
  always_comb begin
    z = 1'b0;
    if (mode == MODE_PULSE) begin
      z = hit_q;
    end else begin
      z = (cnt_q >= thr_s);
    end
  end

  assign z_val   = z_val_q;
  assign run_cnt = cnt_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_run_len_detector.sv
// Self-checking bench for run_len_detector: directed plan steps plus random traffic.
// The reference model uses an unbounded run length and the detector's stated rules.
module tb_run_len_detector;

  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       w = 1'b0;
  logic [3:0] len = 4'd4;
  logic       mode = 1'b0;
  logic       z;
  logic       z_val;
  logic [3:0] run_cnt;
  logic [7:0] evt_cnt;

  int total = 0;
  int bad = 0;

  // model state
  int   m_len = 0;
  logic m_val = 1'b0;
  logic m_hit = 1'b0;
  int   m_evt = 0;

  run_len_detector #(.MAX_LEN(MAX), .CNT_W(4), .EVT_W(8)) dut (
    .clk(clk), .clr(clr), .en(en), .w(w), .len(len), .mode(mode),
    .z(z), .z_val(z_val), .run_cnt(run_cnt), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  function automatic int thr_of(input logic [3:0] l);
    if (l == 4'd0) return 1;
    if (int'(l) > MAX) return MAX;
    return int'(l);
  endfunction

  function automatic int exp_cnt();
    return (m_len > MAX) ? MAX : m_len;
  endfunction

  function automatic logic exp_z();
    if (mode) return m_hit;
    return (exp_cnt() >= thr_of(len));
  endfunction

  task automatic model_edge(input logic c, input logic e, input logic b, input logic [3:0] l);
    if (c) begin
      m_len = 0; m_val = 1'b0; m_hit = 1'b0; m_evt = 0;
    end else if (e) begin
      if (m_len == 0 || b != m_val) begin
        m_len = 1; m_val = b;
      end else if (m_len < 1000) begin
        m_len = m_len + 1;
      end
      // A hit is the moment the true run length equals the threshold.
      m_hit = (m_len == thr_of(l));
      if (m_hit) m_evt = (m_evt + 1) % 256;
    end else begin
      m_hit = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_z"}, 32'(z), 32'(exp_z()));
    chk({tag, "_run_cnt"}, 32'(run_cnt), 32'(exp_cnt()));
    chk({tag, "_evt_cnt"}, 32'(evt_cnt), 32'(m_evt));
    if (m_len != 0) chk({tag, "_z_val"}, 32'(z_val), 32'(m_val));
  endtask

  task automatic step(input string tag, input logic c, input logic e, input logic b);
    clr = c; en = e; w = b;
    @(posedge clk);
    model_edge(c, e, b, len);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic prev_w;
    prev_w = 1'b0;

    // reset and LEVEL len=4: four zeros
    step("reset", 1'b1, 1'b1, 1'b1);
    chk("reset_z", 32'(z), 32'd0);
    chk("reset_zval", 32'(z_val), 32'd0);
    len = 4'd4; mode = 1'b0;
    for (int i = 0; i < 4; i++) step("lvl_zeros", 1'b0, 1'b1, 1'b0);
    chk("lvl_zeros_z", 32'(z), 32'd1);
    chk("lvl_zeros_evt", 32'(evt_cnt), 32'd1);

    // 1,1,1,1,1,0 after a reset
    step("clr2", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("lvl_ones", 1'b0, 1'b1, 1'b1);
    chk("lvl_sat", 32'(run_cnt), 32'd4);
    step("lvl_flip", 1'b0, 1'b1, 1'b0);
    chk("lvl_flip_z", 32'(z), 32'd0);
    chk("lvl_flip_evt", 32'(evt_cnt), 32'd1);

    // lowering len mid-run raises LEVEL z immediately; mode switch takes effect at once
    step("grow", 1'b0, 1'b1, 1'b0);
    len = 4'd2; #1;
    check_all("len_drop");
    mode = 1'b1; #1;
    check_all("mode_pulse_peek");
    mode = 1'b0; len = 4'd4; #1;
    check_all("mode_level_peek");

    // PULSE len=3: 0,0,0,0,1,1,1
    step("clr3", 1'b1, 1'b0, 1'b0);
    mode = 1'b1; len = 4'd3;
    for (int i = 0; i < 4; i++) step("pls_zeros", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("pls_ones", 1'b0, 1'b1, 1'b1);
    chk("pls_z", 32'(z), 32'd1);
    step("pls_idle", 1'b0, 1'b0, 1'b1);
    chk("pls_evt", 32'(evt_cnt), 32'd2);

    // en gaps: 1,1, five idle cycles, 1,1
    step("clr4", 1'b1, 1'b0, 1'b0);
    mode = 1'b0; len = 4'd4;
    step("gap", 1'b0, 1'b1, 1'b1);
    step("gap", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("gap_idle", 1'b0, 1'b0, 1'b0);
    chk("gap_hold", 32'(run_cnt), 32'd2);
    step("gap", 1'b0, 1'b1, 1'b1);
    step("gap", 1'b0, 1'b1, 1'b1);
    chk("gap_z", 32'(z), 32'd1);

    // clr with the 3rd of four zeros
    step("clr5", 1'b1, 1'b0, 1'b0);
    step("clrmid", 1'b0, 1'b1, 1'b0);
    step("clrmid", 1'b0, 1'b1, 1'b0);
    step("clrmid_clr", 1'b1, 1'b1, 1'b0);
    chk("clrmid_cnt", 32'(run_cnt), 32'd0);
    step("clrmid_after", 1'b0, 1'b1, 1'b0);
    chk("clrmid_after_cnt", 32'(run_cnt), 32'd1);

    // len=0 PULSE: every run start hits; event counter wraps
    step("clr6", 1'b1, 1'b0, 1'b0);
    mode = 1'b1; len = 4'd0;
    for (int i = 0; i < 255; i++) step("len0", 1'b0, 1'b1, 1'(i % 2));
    chk("wrap_255", 32'(evt_cnt), 32'd255);
    step("len0_wrap", 1'b0, 1'b1, 1'b1);
    chk("wrap_0", 32'(evt_cnt), 32'd0);

    // len=9 acts as 4: one pulse on the 4th equal sample only
    len = 4'd9;
    step("len9", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step("len9", 1'b0, 1'b1, 1'b0);
    chk("len9_evt", 32'(evt_cnt), 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) len = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 9) < 3) prev_w = 1'($urandom_range(0, 1));
      step("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), prev_w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
